dm_run_ctl: RTL and testbench
=============================

DM_RUN_CTL -- requirements
Module: dm_run_ctl

Interface
REQ-001 SHALL have parameter HALT_TIMEOUT, default 255, number of HALTING cycles before halt_timeout sets (1..65535).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port dmactive  in  1  DM enable; 0 = DM held inactive.
REQ-005 SHALL have port dmcontrol_we  in  1  one-cycle dmcontrol write strobe.
REQ-006 SHALL have port haltreq_wdata  in  1  haltreq field of the write.
REQ-007 SHALL have port resumereq_wdata  in  1  resumereq field of the write.
REQ-008 SHALL have port ackhavereset_wdata  in  1  ackhavereset field of the write.
REQ-009 SHALL have port hart_reset  in  1  one-cycle pulse, hart was reset.
REQ-010 SHALL have port halted  in  1  hart halted status from the debug interface.
REQ-011 SHALL have port halt_req  out  1  level halt request to the hart debug controller.
REQ-012 SHALL have port resume_req  out  1  level resume request to the hart debug controller.
REQ-013 SHALL have ports allhalted, allrunning, allresumeack, allhavereset, halt_timeout  out  1 each  dmstatus bits.
REQ-014 SHALL have port busy  out  1  FSM in HALTING or RESUMING.

Function
REQ-015 SHALL implement FSM states RUNNING, HALTING, HALTED, RESUMING; all outputs registered.
REQ-016 RUNNING: write with haltreq_wdata=1 -> HALTING next cycle; halt_req=1 from cycle N+1 after the write in cycle N.
REQ-017 HALTING: halt_req held 1, not abortable by haltreq_wdata=0; halted=1 sampled -> HALTED, halt_req=0 next cycle.
REQ-018 HALTED: write with resumereq_wdata=1 and haltreq_wdata=0 -> RESUMING, allresumeack cleared same edge, resume_req=1 next cycle.
REQ-019 RESUMING: resume_req held 1; halted=0 sampled -> RUNNING, resume_req=0, allresumeack=1 next cycle.
REQ-020 Write with haltreq_wdata=1 and resumereq_wdata=1 SHALL be treated as haltreq only.
REQ-021 resumereq_wdata=1 outside HALTED SHALL be ignored; allresumeack unchanged.
REQ-022 haltreq_wdata=1 in HALTING or HALTED SHALL have no effect; in RESUMING it SHALL be ignored.
REQ-023 halt_req and resume_req SHALL never be 1 in the same cycle.
REQ-024 allhalted = (state==HALTED); allrunning = (state==RUNNING); both registered with state.
REQ-025 16-bit counter SHALL clear on HALTING entry, increment each HALTING cycle, saturate; reaching HALT_TIMEOUT sets halt_timeout sticky.
REQ-026 halt_timeout SHALL clear on the next accepted haltreq write, or when dmactive=0; halt_req stays asserted after timeout.
REQ-027 hart_reset=1 SHALL set allhavereset, force FSM to RUNNING, drop both requests, and clear the counter next cycle, overriding any same-cycle write.
REQ-028 Write with ackhavereset_wdata=1 SHALL clear allhavereset unless hart_reset=1 in the same cycle.
REQ-029 dmactive=0 SHALL drop requests, clear allresumeack, halt_timeout and counter, set FSM to HALTED if halted=1 else RUNNING, and ignore writes; allhavereset is retained.

Reset
REQ-030 On rst: state=RUNNING, halt_req=0, resume_req=0, allhalted=0, allrunning=1, allresumeack=0, allhavereset=1, halt_timeout=0, busy=0, counter=0.
REQ-031 rst SHALL override every other input in the same cycle.

Structure
REQ-032 FSM state enum and the dmcontrol field bit positions SHALL live in shared package dm_pkg.
REQ-033 Single module, no sub-modules; the timeout counter is inline.

Verification
REQ-034 Halt: reset; write haltreq=1 at cycle 0; halted=1 at cycle 3 -> halt_req high cycles 1..3, allhalted=1 at cycle 4.
REQ-035 Resume: from HALTED, write resumereq=1; halted drops 2 cycles later -> resume_req high 2 cycles, then allresumeack=1, allrunning=1.
REQ-036 Both bits: write haltreq=1 and resumereq=1 in RUNNING -> only halt_req asserts; resume_req stays 0.
REQ-037 Timeout: HALT_TIMEOUT=4, haltreq with halted stuck 0 -> halt_timeout=1 after 4 HALTING cycles, halt_req still 1.
REQ-038 hart_reset in HALTING with a same-cycle ackhavereset write -> RUNNING, halt_req=0, allhavereset stays 1.
REQ-039 dmactive=0 in HALTED with halted=1 -> state HALTED, requests 0; allresumeack and halt_timeout cleared.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared debug-module definitions: run-control state encoding, dmcontrol field
// positions and the per-state status flags derived from the run-control state.
package dm_pkg;

  typedef enum logic [1:0] {
    RUNNING  = 2'd0,
    HALTING  = 2'd1,
    HALTED   = 2'd2,
    RESUMING = 2'd3
  } dm_state_e;

  localparam int unsigned DMCONTROL_HALTREQ_BIT      = 31;
  localparam int unsigned DMCONTROL_RESUMEREQ_BIT    = 30;
  localparam int unsigned DMCONTROL_ACKHAVERESET_BIT = 28;
  localparam int unsigned DMCONTROL_DMACTIVE_BIT     = 0;

  typedef struct packed {
    logic halt_req;
    logic resume_req;
    logic allhalted;
    logic allrunning;
    logic busy;
  } dm_flags_t;

  // Request and status bits that are a pure function of the run-control state.
  function automatic dm_flags_t state_flags(input dm_state_e s);
    dm_flags_t f;
    f.halt_req   = (s == HALTING);
    f.resume_req = (s == RESUMING);
    f.allhalted  = (s == HALTED);
    f.allrunning = (s == RUNNING);
    f.busy       = (s == HALTING) || (s == RESUMING);
    return f;
  endfunction

endpackage

// File: rtl/dm_run_ctl_if.sv
// dmcontrol write / hart status inputs and halt-resume requests plus dmstatus bits.
// master drives the write side and hart status; slave is the run-control block.
interface dm_run_ctl_if;

  logic dmactive;
  logic dmcontrol_we;
  logic haltreq_wdata;
  logic resumereq_wdata;
  logic ackhavereset_wdata;
  logic hart_reset;
  logic halted;

  logic halt_req;
  logic resume_req;
  logic allhalted;
  logic allrunning;
  logic allresumeack;
  logic allhavereset;
  logic halt_timeout;
  logic busy;

  modport master (
    output dmactive, dmcontrol_we, haltreq_wdata, resumereq_wdata,
           ackhavereset_wdata, hart_reset, halted,
    input  halt_req, resume_req, allhalted, allrunning, allresumeack,
           allhavereset, halt_timeout, busy
  );

  modport slave (
    input  dmactive, dmcontrol_we, haltreq_wdata, resumereq_wdata,
           ackhavereset_wdata, hart_reset, halted,
    output halt_req, resume_req, allhalted, allrunning, allresumeack,
           allhavereset, halt_timeout, busy
  );

endinterface

// File: rtl/dm_run_ctl.sv
// Debug-module hart run control: halt/resume FSM, havereset/resumeack tracking, halt timeout.
// Latency: every output registered, reacts one cycle after the sampled input; no backpressure.
module dm_run_ctl
  import dm_pkg::*;
#(
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst,
  dm_run_ctl_if.slave bus
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(HALT_TIMEOUT);

  dm_state_e   state;
  dm_state_e   state_nxt;
  dm_flags_t   flags;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [15:0] cnt_sat;
  logic        resumeack;
  logic        resumeack_nxt;
  logic        havereset;
  logic        havereset_nxt;
  logic        timeout;
  logic        timeout_nxt;
  logic        wr;

  assign wr      = bus.dmactive && bus.dmcontrol_we;
  assign cnt_sat = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    timeout_nxt   = timeout;
    resumeack_nxt = resumeack;
    havereset_nxt = havereset;

    // A hart reset in the same cycle wins over the acknowledge.
    if (bus.hart_reset) begin
      havereset_nxt = 1'b1;
    end else if (wr && bus.ackhavereset_wdata) begin
      havereset_nxt = 1'b0;
    end

    if (!bus.dmactive) begin
      state_nxt     = bus.halted ? HALTED : RUNNING;
      cnt_nxt       = '0;
      timeout_nxt   = 1'b0;
      resumeack_nxt = 1'b0;
    end else if (bus.hart_reset) begin
      state_nxt = RUNNING;
      cnt_nxt   = '0;
    end else begin
      case (state)
        RUNNING: begin
          if (wr && bus.haltreq_wdata) begin
            state_nxt   = HALTING;
            cnt_nxt     = '0;
            timeout_nxt = 1'b0;
          end
        end
        HALTING: begin
          if (bus.halted) begin
            state_nxt = HALTED;
          end else begin
            cnt_nxt = cnt_sat;
            if (cnt_sat >= TIMEOUT_CNT) timeout_nxt = 1'b1;
          end
        end
        HALTED: begin
          if (wr && bus.resumereq_wdata && !bus.haltreq_wdata) begin
            state_nxt     = RESUMING;
            resumeack_nxt = 1'b0;
          end
        end
        RESUMING: begin
          if (!bus.halted) begin
            state_nxt     = RUNNING;
            resumeack_nxt = 1'b1;
          end
        end
        default: state_nxt = RUNNING;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUNNING;
      flags     <= state_flags(RUNNING);
      cnt       <= '0;
      timeout   <= 1'b0;
      resumeack <= 1'b0;
      havereset <= 1'b1;
    end else begin
      state     <= state_nxt;
      flags     <= state_flags(state_nxt);
      cnt       <= cnt_nxt;
      timeout   <= timeout_nxt;
      resumeack <= resumeack_nxt;
      havereset <= havereset_nxt;
    end
  end

  assign bus.halt_req     = flags.halt_req;
  assign bus.resume_req   = flags.resume_req;
  assign bus.allhalted    = flags.allhalted;
  assign bus.allrunning   = flags.allrunning;
  assign bus.busy         = flags.busy;
  assign bus.allresumeack = resumeack;
  assign bus.allhavereset = havereset;
  assign bus.halt_timeout = timeout;

endmodule

// File: tb/tb_dm_run_ctl.sv
// Scoreboard bench for dm_run_ctl: driver pushes predicted status per cycle,
// monitor pops and compares after each clock edge.
module tb_dm_run_ctl;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dm_run_ctl_if bus ();

  dm_run_ctl #(.HALT_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic [7:0] mon_act;

  // Reference model: hart phase plus an unbounded count of stalled halting cycles.
  typedef enum {P_RUN, P_HALTING, P_HALTED, P_RESUMING} phase_t;
  phase_t ph      = P_RUN;
  int     hcyc    = 0;
  bit     m_ack   = 1'b0;
  bit     m_hr    = 1'b1;
  bit     m_tmo   = 1'b0;
  bit     hl_rand = 1'b0;

  // {halt_req, resume_req, allhalted, allrunning, allresumeack, allhavereset, halt_timeout, busy}
  function automatic logic [7:0] expect_vec();
    return {ph == P_HALTING, ph == P_RESUMING, ph == P_HALTED, ph == P_RUN,
            m_ack, m_hr, m_tmo, (ph == P_HALTING) || (ph == P_RESUMING)};
  endfunction

  task automatic step(input bit r, input bit dma, input bit we, input bit hq,
                      input bit rq, input bit ak, input bit hrst, input bit hl);
    @(negedge clk);
    rst                    = r;
    bus.dmactive           = dma;
    bus.dmcontrol_we       = we;
    bus.haltreq_wdata      = hq;
    bus.resumereq_wdata    = rq;
    bus.ackhavereset_wdata = ak;
    bus.hart_reset         = hrst;
    bus.halted             = hl;
    if (r) begin
      ph = P_RUN; m_ack = 1'b0; m_hr = 1'b1; m_tmo = 1'b0; hcyc = 0;
    end else if (!dma) begin
      ph = hl ? P_HALTED : P_RUN;
      m_ack = 1'b0; m_tmo = 1'b0; hcyc = 0;
      if (hrst) m_hr = 1'b1;
    end else if (hrst) begin
      ph = P_RUN; hcyc = 0; m_hr = 1'b1;
    end else begin
      if (we && ak) m_hr = 1'b0;
      case (ph)
        P_RUN:      if (we && hq) begin ph = P_HALTING; hcyc = 0; m_tmo = 1'b0; end
        P_HALTING:  if (hl) ph = P_HALTED;
                    else begin hcyc++; if (hcyc >= TO) m_tmo = 1'b1; end
        P_HALTED:   if (we && rq && !hq) begin ph = P_RESUMING; m_ack = 1'b0; end
        P_RESUMING: if (!hl) begin ph = P_RUN; m_ack = 1'b1; end
      endcase
    end
    exp_q.push_back(expect_vec());
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {bus.halt_req, bus.resume_req, bus.allhalted, bus.allrunning,
                   bus.allresumeack, bus.allhavereset, bus.halt_timeout, bus.busy};
        total++;
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL status cyc=%0d got=%b want=%b (hreq,rreq,ahalt,arun,rack,hvrst,tmo,busy)",
                   cyc, mon_act, mon_exp);
        end
        total++;
        if (bus.halt_req && bus.resume_req) begin
          bad++;
          $display("FAIL req_exclusive cyc=%0d got halt_req=1 resume_req=1 want not both", cyc);
        end
      end
    end
  end

  initial begin
    bus.dmactive = 1'b1; bus.dmcontrol_we = 1'b0; bus.haltreq_wdata = 1'b0;
    bus.resumereq_wdata = 1'b0; bus.ackhavereset_wdata = 1'b0;
    bus.hart_reset = 1'b0; bus.halted = 1'b0;

    repeat (2) step(1, 1, 0, 0, 0, 0, 0, 0);

    // Halt: write at cycle 0, hart reports halted at cycle 3.
    step(0, 1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    // Resume: halted drops two cycles after the write.
    step(0, 1, 1, 0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    // Resume request outside HALTED is ignored.
    step(0, 1, 1, 0, 1, 0, 0, 0);
    // Both bits in RUNNING behave as halt only.
    step(0, 1, 1, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    // Hart reset in HALTING beats a same-cycle ackhavereset write.
    step(0, 1, 1, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1, 0, 0);
    // Timeout with halted stuck low, then late halt.
    step(0, 1, 1, 1, 0, 0, 0, 0);
    repeat (7) step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0, 1);
    // dmactive low while halted.
    step(0, 0, 1, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      bit r, dma, we, hq, rq, ak, hrst;
      if ($urandom_range(7) == 0) hl_rand = ~hl_rand;
      r    = ($urandom_range(199) == 0);
      dma  = ($urandom_range(29) != 0);
      we   = ($urandom_range(2) == 0);
      hq   = ($urandom_range(2) == 0);
      rq   = ($urandom_range(1) == 0);
      ak   = ($urandom_range(3) == 0);
      hrst = ($urandom_range(39) == 0);
      step(r, dma, we, hq, rq, ak, hrst, hl_rand);
    end

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
